// File: rtl/mat_stream_driver.sv
// Initiator for the mat_mul accelerator: streams operand buffers A then B, pulses start,
// then captures the result stream. Define MAT_STREAM_TIMEOUT_EN to add a RECV watchdog.
//
// state  | meaning
// IDLE   | waiting for go; load port writes operand buffers
// SEND_A | streaming A buffer, sel=0
// GAP    | one dead cycle while sel switches to B
// SEND_B | streaming B buffer, sel=1
// START  | one-cycle compute trigger
// RECV   | accepting result beats into the result buffer
// DONE   | one-cycle completion pulse
module mat_stream_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_LOG    = 1
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    ld_we,
    input  logic                    ld_sel,
    input  logic [2*DIM_LOG-1:0]    ld_addr,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic                    go,
    output logic                    busy,
    output logic                    done,
    output logic                    len_err,
    input  logic [2*DIM_LOG-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                    m00_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    input  logic                    m00_axis_tready,
    input  logic                    s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    output logic                    sel,
    output logic                    start
);
    localparam int AW = 2*DIM_LOG;
    localparam int NE = 1 << AW;
    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

    typedef enum logic [2:0] {IDLE, SEND_A, GAP, SEND_B, START, RECV, DONE} state_t;

    state_t state, state_nx;
    logic [AW-1:0] idx;
    logic idx_clr, idx_inc, err_set, err_clr, res_we;
    logic [DATA_WIDTH-1:0] a_buf   [NE];
    logic [DATA_WIDTH-1:0] b_buf   [NE];
    logic [DATA_WIDTH-1:0] res_buf [NE];

`ifdef MAT_STREAM_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic wd_load, wd_dec;

    // Down-counter of idle RECV cycles; terminal count 1 means 65535 silent cycles.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)
            wd_cnt <= '1;
        else if (wd_load)
            wd_cnt <= '1;
        else if (wd_dec)
            wd_cnt <= wd_cnt - 1'b1;
    end
`endif

    assign m00_axis_tstrb = '1;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        idx_clr         = 1'b0;
        idx_inc         = 1'b0;
        err_set         = 1'b0;
        err_clr         = 1'b0;
        res_we          = 1'b0;
        busy            = (state != IDLE);
        done            = 1'b0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tlast  = 1'b0;
        s00_axis_tready = 1'b0;
        sel             = 1'b0;
        start           = 1'b0;
`ifdef MAT_STREAM_TIMEOUT_EN
        wd_load         = 1'b0;
        wd_dec          = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (go) begin
                    state_nx = SEND_A;
                    idx_clr  = 1'b1;
                    err_clr  = 1'b1;
                end
            end
            SEND_A: begin
                m00_axis_tvalid = 1'b1;
                m00_axis_tdata  = a_buf[idx];
                m00_axis_tlast  = (idx == IDX_LAST);
                if (m00_axis_tready) begin
                    idx_inc = 1'b1;
                    if (idx == IDX_LAST)
                        state_nx = GAP;
                end
            end
            GAP: begin
                sel      = 1'b1;
                idx_clr  = 1'b1;
                state_nx = SEND_B;
            end
            SEND_B: begin
                sel             = 1'b1;
                m00_axis_tvalid = 1'b1;
                m00_axis_tdata  = b_buf[idx];
                m00_axis_tlast  = (idx == IDX_LAST);
                if (m00_axis_tready) begin
                    idx_inc = 1'b1;
                    if (idx == IDX_LAST)
                        state_nx = START;
                end
            end
            START: begin
                sel      = 1'b1;
                start    = 1'b1;
                idx_clr  = 1'b1;
                state_nx = RECV;
`ifdef MAT_STREAM_TIMEOUT_EN
                wd_load  = 1'b1;
`endif
            end
            RECV: begin
                sel             = 1'b1;
                s00_axis_tready = 1'b1;
                if (s00_axis_tvalid) begin
                    res_we  = 1'b1;
                    idx_inc = 1'b1;
`ifdef MAT_STREAM_TIMEOUT_EN
                    wd_load = 1'b1;
`endif
                    // Either end marker ends the run; only both together is a clean length.
                    if (s00_axis_tlast || idx == IDX_LAST) begin
                        err_set  = !(s00_axis_tlast && idx == IDX_LAST);
                        state_nx = DONE;
                    end
                end
`ifdef MAT_STREAM_TIMEOUT_EN
                else if (wd_cnt == 16'd1) begin
                    err_set  = 1'b1;
                    state_nx = DONE;
                end
                else begin
                    wd_dec = 1'b1;
                end
`endif
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            idx     <= '0;
            len_err <= 1'b0;
            rd_data <= '0;
        end else begin
            if (idx_clr)
                idx <= '0;
            else if (idx_inc)
                idx <= idx + 1'b1;
            if (err_clr)
                len_err <= 1'b0;
            else if (err_set)
                len_err <= 1'b1;
            rd_data <= res_buf[rd_addr];
        end
    end

    // Storage is deliberately not reset; contents persist across runs and resets.
    always_ff @(posedge s00_axi_aclk) begin
        if (ld_we && state == IDLE) begin
            if (ld_sel)
                b_buf[ld_addr] <= ld_data;
            else
                a_buf[ld_addr] <= ld_data;
        end
        if (res_we)
            res_buf[idx] <= s00_axis_tdata;
    end

endmodule
